bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 122 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with start/stop/load edge controls.
// Counts down once per TICK_DIV clocks and blinks a dash display once expired.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW = 26;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [3:0]      tens_q;
    logic [3:0]      ones_q;
    logic [PW-1:0]   presc_q;
    logic            blink_q;
    logic            start_prev_q;
    logic            stop_prev_q;
    logic            load_prev_q;

    logic            start_req;
    logic            stop_req;
    logic            load_req;
    logic            wrap;
    logic [3:0]      tens_load;
    logic [3:0]      ones_load;

    assign start_req = start & ~start_prev_q;
    assign stop_req  = stop  & ~stop_prev_q;
    assign load_req  = load  & ~load_prev_q;
    assign wrap      = (presc_q == PRESC_MAX);
    assign tens_load = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
    assign ones_load = (preset_ones > 4'd9) ? 4'd9 : preset_ones;

    // Control FSM, BCD count, prescaler and blink; load overrides everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            presc_q      <= '0;
            blink_q      <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            load_prev_q  <= 1'b0;
        end else begin
            start_prev_q <= start;
            stop_prev_q  <= stop;
            load_prev_q  <= load;
            if (load_req) begin
                state_q <= IDLE;
                tens_q  <= tens_load;
                ones_q  <= ones_load;
                presc_q <= '0;
                blink_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_req && !stop_req && (tens_q != 4'd0 || ones_q != 4'd0))
                            state_q <= RUN;
                    end
                    RUN: begin
                        if (stop_req) begin
                            state_q <= PAUSE;
                        end else if (wrap) begin
                            presc_q <= '0;
                            if (tens_q == 4'd0 && ones_q == 4'd1) begin
                                ones_q  <= 4'd0;
                                state_q <= DONE;
                                blink_q <= 1'b0;
                            end else if (ones_q == 4'd0) begin
                                ones_q <= 4'd9;
                                tens_q <= tens_q - 4'd1;
                            end else begin
                                ones_q <= ones_q - 4'd1;
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    PAUSE: begin
                        if (start_req && !stop_req)
                            state_q <= RUN;
                    end
                    DONE: begin
                        if (wrap) begin
                            presc_q <= '0;
                            blink_q <= ~blink_q;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Outputs decode purely from registered state.
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign tens    = done ? (blink_q ? 4'd10 : 4'd0) : tens_q;
    assign ones    = done ? (blink_q ? 4'd10 : 4'd0) : ones_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed self-checking bench for bcd_countdown_timer with TICK_DIV=4.
module tb_bcd_countdown_timer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start, stop, load;
    logic [3:0] preset_tens, preset_ones;
    logic [3:0] tens, ones;
    logic       running, done;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct packed {
        logic       s;
        logic       p;
        logic       l;
        logic [3:0] pt;
        logic [3:0] po;
        logic [3:0] et;
        logic [3:0] eo;
        logic       er;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .load        (load),
        .preset_tens (preset_tens),
        .preset_ones (preset_ones),
        .tens        (tens),
        .ones        (ones),
        .running     (running),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic add(input logic s, input logic p, input logic l,
                       input logic [3:0] pt, input logic [3:0] po,
                       input logic [3:0] et, input logic [3:0] eo,
                       input logic er, input logic ed);
        vec_t v;
        v = '{s: s, p: p, l: l, pt: pt, po: po, et: et, eo: eo, er: er, ed: ed};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] et, input logic [3:0] eo,
                         input logic er, input logic ed);
        n_checks++;
        if (tens !== et || ones !== eo || running !== er || done !== ed) begin
            n_fails++;
            $display("FAIL %s: got tens=%0d ones=%0d running=%0b done=%0b, want tens=%0d ones=%0d running=%0b done=%0b",
                     name, tens, ones, running, done, et, eo, er, ed);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; load = 1'b0;
        preset_tens = 4'd0; preset_ones = 4'd0;

        //   s  p  l  pt  po   tens ones run done
        add(0, 0, 1, 1,  2,   1,  2,  0, 0);   // load 12
        add(1, 0, 0, 1,  2,   1,  2,  1, 0);   // start edge -> RUN
        add(1, 0, 0, 1,  2,   1,  2,  1, 0);   // start held: no new edge
        add(0, 0, 0, 1,  2,   1,  2,  1, 0);
        add(0, 0, 0, 1,  2,   1,  2,  1, 0);
        add(0, 0, 0, 1,  2,   1,  1,  1, 0);   // 4 cycles: 11
        add(0, 0, 0, 1,  2,   1,  1,  1, 0);
        add(0, 0, 0, 1,  2,   1,  1,  1, 0);
        add(0, 0, 0, 1,  2,   1,  1,  1, 0);
        add(0, 0, 0, 1,  2,   1,  0,  1, 0);   // 8 cycles: 10
        add(0, 0, 0, 1,  2,   1,  0,  1, 0);
        add(0, 0, 0, 1,  2,   1,  0,  1, 0);
        add(1, 0, 0, 1,  2,   1,  0,  1, 0);   // start edge in RUN ignored
        add(0, 0, 0, 1,  2,   0,  9,  1, 0);   // borrow: 09
        add(0, 0, 1, 0,  1,   0,  1,  0, 0);   // load 01
        add(1, 0, 0, 0,  1,   0,  1,  1, 0);
        add(0, 0, 0, 0,  1,   0,  1,  1, 0);
        add(0, 0, 0, 0,  1,   0,  1,  1, 0);
        add(0, 0, 0, 0,  1,   0,  1,  1, 0);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);   // 01 -> 00, DONE same edge
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,  10, 10,  0, 1);   // blink on
        add(1, 1, 0, 0,  1,  10, 10,  0, 1);   // start/stop ignored in DONE
        add(0, 0, 0, 0,  1,  10, 10,  0, 1);
        add(0, 0, 0, 0,  1,  10, 10,  0, 1);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);   // blink off
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,   0,  0,  0, 1);
        add(0, 0, 0, 0,  1,  10, 10,  0, 1);
        add(1, 1, 1, 9, 15,   9,  9,  0, 0);   // all edges, clamp 9/15 -> 99
        add(0, 0, 0, 9, 15,   9,  9,  0, 0);
        add(0, 1, 0, 9, 15,   9,  9,  0, 0);   // stop in IDLE ignored
        add(0, 0, 1, 0,  0,   0,  0,  0, 0);   // load 00
        add(1, 0, 0, 0,  0,   0,  0,  0, 0);   // start with 00 stays IDLE
        add(0, 0, 0, 0,  0,   0,  0,  0, 0);
        add(0, 0, 1, 2,  0,   2,  0,  0, 0);   // load 20
        add(1, 0, 0, 2,  0,   2,  0,  1, 0);
        add(0, 0, 0, 2,  0,   2,  0,  1, 0);
        add(0, 0, 0, 2,  0,   2,  0,  1, 0);   // prescaler now 2

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 4'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].s; stop = vecs[i].p; load = vecs[i].l;
            preset_tens = vecs[i].pt; preset_ones = vecs[i].po;
            cyc();
            check($sformatf("vec%0d", i), vecs[i].et, vecs[i].eo, vecs[i].er, vecs[i].ed);
        end

        // Pause with prescaler=2, hold 10 cycles, resume: tick 2 cycles later.
        start = 1'b0; stop = 1'b1;
        cyc();
        check("pause_enter", 4'd2, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc();
            check($sformatf("pause_hold%0d", i), 4'd2, 4'd0, 1'b0, 1'b0);
        end
        stop = 1'b0; start = 1'b1;
        cyc();
        check("resume", 4'd2, 4'd0, 1'b1, 1'b0);
        start = 1'b0;
        cyc();
        check("resume_plus1", 4'd2, 4'd0, 1'b1, 1'b0);
        cyc();
        check("resume_tick", 4'd1, 4'd9, 1'b1, 1'b0);

        // Asynchronous reset mid-RUN, between clock edges.
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        repeat (5) cyc();
        check("reset_hold", 4'd0, 4'd0, 1'b0, 1'b0);

        // Level already high at release counts as an edge.
        load = 1'b1; preset_tens = 4'd3; preset_ones = 4'd4;
        cyc();
        check("load_in_reset", 4'd0, 4'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc();
        check("load_after_release", 4'd3, 4'd4, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        cyc();
        check("start_after_release", 4'd3, 4'd4, 1'b1, 1'b0);
        start = 1'b0;
        repeat (4) cyc();
        check("tick_after_release", 4'd3, 4'd3, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
